alu_seq: RTL

- Parametrised, registered successor to the combinational ALU.
- Accepts one operation per valid/ready handshake and returns a registered result plus N/Z/C/V condition codes.
- Adds an iterative multiply. Divide/remainder are optional.
- Sits between the decode/operand-read stage and writeback of the 2stage core, and stalls the issuing stage while a multi-cycle op is running.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_seq_if.sv | 33 +++
 rtl/alu_iter_md.sv | 146 ++++++++++++++
 rtl/alu_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU (alu_seq) and its iterative
// multiply/divide datapath (alu_iter_md).
//   - op_e     : operation codes presented on the op port
//   - IDLE/ITER/DONE : handshake FSM state encodings
//   - CC_*     : bit positions inside the 4-bit condition-code word
//   - pack_cc  : assembles N/Z/C/V into a condition-code word
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_SRA  = 4'd7,
    OP_MUL  = 4'd8,
    OP_DIVU = 4'd10,
    OP_REMU = 4'd11
  } op_e;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CC_N = 3;
  localparam int CC_Z = 2;
  localparam int CC_C = 1;
  localparam int CC_V = 0;

  function automatic logic [3:0] pack_cc(input logic n, input logic z,
                                         input logic c, input logic v);
    logic [3:0] cc;
    cc       = '0;
    cc[CC_N] = n;
    cc[CC_Z] = z;
    cc[CC_C] = c;
    cc[CC_V] = v;
    return cc;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if
// Handshake/bus bundle between the issuing stage (master) and alu_seq (slave).
//   in_valid/in_ready   : operation handshake, op/a/b carried with it
//   out_valid/out_ready : result handshake, result/cc carried with it
//   busy                : an iterative operation is in progress
// -----------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       cc;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, cc, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, cc, busy
  );

endinterface

// File: rtl/alu_iter_md.sv
// -----------------------------------------------------------------------------
// alu_iter_md
// Iterative datapath for the multi-cycle ALU operations. One step per clock,
// WIDTH steps per operation, sharing one iteration counter.
//   MUL  : unsigned shift-add, low WIDTH bits of the product
//   DIVU / REMU : unsigned restoring division (only when ALU_SEQ_DIV_EN is
//          defined; otherwise no divider logic exists)
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : load operands and begin (one-cycle pulse)
//   div_sel, rem_sel : (ALU_SEQ_DIV_EN only) select DIVU / REMU at start
//   a, b             : operands, sampled on the start edge
//   done             : high during the final step; res is valid then
//   res              : result of the final step
// -----------------------------------------------------------------------------
module alu_iter_md #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef ALU_SEQ_DIV_EN
  input  logic             div_sel,
  input  logic             rem_sel,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  import alu_pkg::*;

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic              active_q, active_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W2-1:0]     prod_q, prod_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic [WIDTH:0]    add_sum;
  logic [W2-1:0]     mul_next;
  logic [W2-1:0]     step_next;
`ifdef ALU_SEQ_DIV_EN
  logic              div_q, div_d;
  logic              rem_q, rem_d;
  logic [WIDTH:0]    trial;
  logic [W2-1:0]     div_next;
`endif

  // One shift-add multiply step on {hi, lo}: lo starts as the multiplier and
  // is consumed from bit 0 while the partial product grows into hi. The carry
  // of the add is kept by shifting the whole (WIDTH+1)-bit sum back in.
  always_comb begin
    add_sum  = {1'b0, prod_q[W2-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {add_sum, prod_q[WIDTH-1:1]};
  end

`ifdef ALU_SEQ_DIV_EN
  // One restoring-division step on {remainder, quotient}: shift left, try to
  // subtract the divisor, keep the difference and set the quotient bit if it
  // did not go negative. A zero divisor naturally yields an all-ones quotient
  // and leaves the dividend as the remainder.
  always_comb begin
    trial    = prod_q[W2-1:WIDTH-1] - {1'b0, opnd_q};
    div_next = trial[WIDTH] ? {prod_q[W2-2:0], 1'b0}
                            : {trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
  end
`endif

  always_comb begin
`ifdef ALU_SEQ_DIV_EN
    step_next = div_q ? div_next : mul_next;
`else
    step_next = mul_next;
`endif
  end

  // Load on start, otherwise step while active. done and res are taken from
  // the step being computed so the caller can register the answer on the
  // same edge that completes the last iteration.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    opnd_d   = opnd_q;
    done     = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    div_d    = div_q;
    rem_d    = rem_q;
`endif
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      prod_d   = {{WIDTH{1'b0}}, b};
      opnd_d   = a;
`ifdef ALU_SEQ_DIV_EN
      div_d    = div_sel | rem_sel;
      rem_d    = rem_sel;
      if (div_sel | rem_sel) begin
        prod_d = {{WIDTH{1'b0}}, a};
        opnd_d = b;
      end
`endif
    end else if (active_q) begin
      prod_d = step_next;
      cnt_d  = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        done     = 1'b1;
        active_d = 1'b0;
      end
    end
  end

  always_comb begin
`ifdef ALU_SEQ_DIV_EN
    res = rem_q ? step_next[W2-1:WIDTH] : step_next[WIDTH-1:0];
`else
    res = step_next[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
      opnd_q   <= '0;
`ifdef ALU_SEQ_DIV_EN
      div_q    <= 1'b0;
      rem_q    <= 1'b0;
`endif
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      opnd_q   <= opnd_d;
`ifdef ALU_SEQ_DIV_EN
      div_q    <= div_d;
      rem_q    <= rem_d;
`endif
    end
  end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Registered, handshaked ALU. Single-cycle ops (ADD..SRA) complete on the
// accept edge; MUL (and DIVU/REMU when ALU_SEQ_DIV_EN is defined) run for
// WIDTH cycles in alu_iter_md. Undefined ops return 0 with only Z set.
// Optional feature macro: ALU_SEQ_DIV_EN (enables DIVU=10, REMU=11).
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_seq_if slave modport - in_valid/in_ready/op/a/b,
//           out_valid/out_ready/result/cc, busy
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);

  import alu_pkg::*;

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       cc_q, cc_d;

  logic             in_ready;
  logic             fire;
  logic             iter_op;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_res;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic             shift_oor;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [3:0]       alu_cc;

  // A finished result may be replaced in the same cycle it is consumed,
  // giving one single-cycle op per clock.
  assign in_ready      = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign fire          = bus.in_valid & in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == ITER);
  assign bus.result    = result_q;
  assign bus.cc        = cc_q;

  always_comb begin
`ifdef ALU_SEQ_DIV_EN
    iter_op = (bus.op == OP_MUL) | (bus.op == OP_DIVU) | (bus.op == OP_REMU);
`else
    iter_op = (bus.op == OP_MUL);
`endif
  end

  // Single-cycle datapath. Shift amounts of WIDTH or more fall outside the
  // barrel shifter and are handled explicitly.
  always_comb begin
    sum       = {1'b0, bus.a} + {1'b0, bus.b};
    dif       = {1'b0, bus.a} - {1'b0, bus.b};
    shift_oor = (bus.b >= WIDTH_V);
    shamt     = bus.b[SHW-1:0];
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                  (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif[WIDTH-1:0];
        alu_c   = ~dif[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                  (dif[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_SHL: alu_res = shift_oor ? '0 : (bus.a << shamt);
      OP_SHR: alu_res = shift_oor ? '0 : (bus.a >> shamt);
      OP_SRA: alu_res = shift_oor ? {WIDTH{bus.a[WIDTH-1]}}
                                  : WIDTH'($signed(bus.a) >>> shamt);
      default: alu_res = '0;
    endcase
    alu_cc = pack_cc(alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v);
  end

  // Handshake FSM. Results and flags are only written on completion, so DONE
  // holds them steady for as long as the consumer stalls.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    cc_d       = cc_q;
    iter_start = 1'b0;
    case (state_q)
      ITER: begin
        if (iter_done) begin
          state_d  = DONE;
          result_d = iter_res;
          cc_d     = pack_cc(iter_res[WIDTH-1], (iter_res == '0), 1'b0, 1'b0);
        end
      end
      default: begin
        if (fire) begin
          if (iter_op) begin
            state_d    = ITER;
            iter_start = 1'b1;
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            cc_d     = alu_cc;
          end
        end else if ((state_q == DONE) && bus.out_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      cc_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cc_q     <= cc_d;
    end
  end

  alu_iter_md #(
    .WIDTH(WIDTH)
  ) u_iter_md (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (iter_start),
`ifdef ALU_SEQ_DIV_EN
    .div_sel (bus.op == OP_DIVU),
    .rem_sel (bus.op == OP_REMU),
`endif
    .a       (bus.a),
    .b       (bus.b),
    .done    (iter_done),
    .res     (iter_res)
  );

endmodule
